// File: rtl/eth_pkg.sv
// eth_pkg: shared definitions for the RMII receive path.
//   rx_state_t      : deframer state encoding
//   PREAMBLE_DIBIT  : 2'b01 preamble dibit
//   SFD_DIBIT       : 2'b11 start-of-frame-delimiter dibit
//   CRC32_*         : reflected Ethernet CRC-32 polynomial, seed and good-frame residue
`timescale 1ns/1ps
package eth_pkg;

   typedef enum logic [2:0] {
      ST_DISARM,
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_DROP
   } rx_state_t;

   localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
   localparam logic [1:0]  SFD_DIBIT      = 2'b11;

   localparam logic [31:0] CRC32_POLY     = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE  = 32'hDEBB20E3;

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: combinational byte-wide next-state of the reflected Ethernet CRC-32.
// Bits are consumed LSB first, matching the on-wire order.
//   crc_in  in  32  current CRC register
//   data    in  8   byte to absorb
//   crc_out out 32  CRC register after absorbing data
`timescale 1ns/1ps
module crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   always_comb begin
      logic [31:0] c;
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         c = {1'b0, c[31:1]} ^ (((c[0] ^ data[i]) == 1'b1) ? CRC32_POLY : 32'h0);
      end
      crc_out = c;
   end

endmodule

// File: rtl/rmii_rx_deframer.sv
// rmii_rx_deframer: RMII (100 Mbit/s) receive deframer in the eth_clk domain.
// Strips preamble/SFD and delivers payload bytes (FCS included) as strobes.
// Optional build macro: RMII_RX_CRC_CHECK_EN adds a CRC-32 check flagged on rx_err.
// Ports:
//   eth_clk     in   50 MHz RMII reference clock
//   rst         in   synchronous active-high reset
//   rmii_crs_dv in   PHY carrier-sense/data-valid
//   rmii_rxd    in   PHY dibit, LSB first
//   rx_data     out  received byte, valid with rx_valid
//   rx_valid    out  one-cycle byte strobe
//   rx_sof      out  first byte after SFD (with rx_valid)
//   rx_eof      out  end-of-frame strobe, never with rx_valid
//   rx_err      out  frame bad, qualified by rx_eof
//   rx_len      out  delivered byte count (saturates at MAX_BYTES), qualified by rx_eof
`timescale 1ns/1ps
module rmii_rx_deframer
   import eth_pkg::*;
#(
   parameter int MAX_BYTES      = 1522,
   parameter int MIN_PRE_DIBITS = 4
)(
   input  logic                             eth_clk,
   input  logic                             rst,
   input  logic                             rmii_crs_dv,
   input  logic [1:0]                       rmii_rxd,
   output logic [7:0]                       rx_data,
   output logic                             rx_valid,
   output logic                             rx_sof,
   output logic                             rx_eof,
   output logic                             rx_err,
   output logic [$clog2(MAX_BYTES+1)-1:0]   rx_len
);

   localparam int LEN_W = $clog2(MAX_BYTES + 1);
   localparam int PRE_W = $clog2(MIN_PRE_DIBITS + 1);

   logic             dv_p0, dv_p1;
   logic [1:0]       rxd_p0, rxd_p1;
   rx_state_t        state;
   logic [PRE_W-1:0] pre_cnt;
   logic [1:0]       dib_cnt;
   logic [LEN_W-1:0] byte_cnt;
   logic             ovf;
   logic [5:0]       shreg;
   logic [7:0]       byte_p1;
   logic             carrier_end, in_pre, sfd_hit, take_data, byte_ok, crc_bad;

   // ---- stage p0: IOB capture, p1: one-sample lookahead delay ----
   // dv resets high so DISARM only leaves on two genuine low samples.
   always_ff @(posedge eth_clk) begin
      if (rst) begin
         dv_p0 <= 1'b1;
         dv_p1 <= 1'b1;
      end else begin
         dv_p0 <= rmii_crs_dv;
         dv_p1 <= dv_p0;
      end
   end

   always_ff @(posedge eth_clk) begin
      rxd_p0 <= rmii_rxd;
      rxd_p1 <= rxd_p0;
      if (take_data) shreg <= {rxd_p1, shreg[5:2]};
   end

   // The p1 dibit is committed unless both it and the newer p0 sample have
   // crs_dv low; that same condition is the end of frame, so every cycle is
   // exactly one of "commit" or "carrier end".
   always_comb begin
      carrier_end = !dv_p1 && !dv_p0;
      in_pre      = (state == ST_IDLE) || (state == ST_PREAMBLE);
      sfd_hit     = in_pre && !carrier_end && (rxd_p1 == SFD_DIBIT) &&
                    (pre_cnt == PRE_W'(MIN_PRE_DIBITS));
      take_data   = (state == ST_DATA) && !carrier_end;
      byte_ok     = take_data && (dib_cnt == 2'd3) && (byte_cnt != LEN_W'(MAX_BYTES));
      byte_p1     = {rxd_p1, shreg};
   end

`ifdef RMII_RX_CRC_CHECK_EN
   logic [31:0] crc, crc_next;

   crc32_d8 u_crc (
      .crc_in  (crc),
      .data    (byte_p1),
      .crc_out (crc_next)
   );

   always_ff @(posedge eth_clk) begin
      if (sfd_hit)      crc <= CRC32_INIT;
      else if (byte_ok) crc <= crc_next;
   end

   assign crc_bad = (crc != CRC32_RESIDUE);
`else
   assign crc_bad = 1'b0;
`endif

   // ---- stage p2: framing FSM and registered outputs ----
   always_ff @(posedge eth_clk) begin
      if (rst) begin
         state    <= ST_DISARM;
         pre_cnt  <= '0;
         dib_cnt  <= '0;
         byte_cnt <= '0;
         ovf      <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_sof   <= 1'b0;
         rx_eof   <= 1'b0;
         rx_err   <= 1'b0;
         rx_len   <= '0;
      end else begin
         rx_valid <= 1'b0;
         rx_sof   <= 1'b0;
         rx_eof   <= 1'b0;
         case (state)
            ST_DISARM: begin
               pre_cnt <= '0;
               if (carrier_end) state <= ST_IDLE;
            end
            ST_IDLE, ST_PREAMBLE: begin
               if (carrier_end) begin
                  state   <= ST_IDLE;
                  pre_cnt <= '0;
               end else if (sfd_hit) begin
                  state    <= ST_DATA;
                  pre_cnt  <= '0;
                  dib_cnt  <= '0;
                  byte_cnt <= '0;
                  ovf      <= 1'b0;
               end else if (rxd_p1 == PREAMBLE_DIBIT) begin
                  state <= ST_PREAMBLE;
                  if (pre_cnt != PRE_W'(MIN_PRE_DIBITS)) pre_cnt <= pre_cnt + PRE_W'(1);
               end else if ((rxd_p1 == 2'b00) && (pre_cnt == '0)) begin
                  state <= ST_PREAMBLE;
               end else begin
                  state   <= ST_DROP;
                  pre_cnt <= '0;
               end
            end
            ST_DATA: begin
               if (carrier_end) begin
                  state  <= ST_IDLE;
                  rx_eof <= 1'b1;
                  rx_len <= byte_cnt;
                  rx_err <= ovf || (dib_cnt != 2'd0) || crc_bad;
               end else begin
                  dib_cnt <= dib_cnt + 2'd1;
                  if (byte_ok) begin
                     rx_valid <= 1'b1;
                     rx_sof   <= (byte_cnt == '0);
                     rx_data  <= byte_p1;
                     byte_cnt <= byte_cnt + LEN_W'(1);
                  end else if (dib_cnt == 2'd3) begin
                     ovf <= 1'b1;
                  end
               end
            end
            ST_DROP: begin
               pre_cnt <= '0;
               if (carrier_end) state <= ST_IDLE;
            end
            default: state <= ST_DISARM;
         endcase
      end
   end

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// tb_rmii_rx_deframer: self-checking bench for rmii_rx_deframer.
// Frames are built at byte level (random payload + computed FCS), serialised
// to dibits, and expected bytes/latency/end-of-frame results are derived from
// the frame description. Build with RMII_RX_CRC_CHECK_EN to cover the CRC check.
`timescale 1ns/1ps
module tb_rmii_rx_deframer;

   localparam int MAX_BYTES = 1522;
   localparam int MIN_PRE   = 4;
   localparam int LEN_W     = $clog2(MAX_BYTES + 1);
`ifdef RMII_RX_CRC_CHECK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   logic             eth_clk = 1'b0;
   logic             rst = 1'b1;
   logic             rmii_crs_dv = 1'b0;
   logic [1:0]       rmii_rxd = 2'b00;
   logic [7:0]       rx_data;
   logic             rx_valid, rx_sof, rx_eof, rx_err;
   logic [LEN_W-1:0] rx_len;

   always #10 eth_clk = ~eth_clk;

   rmii_rx_deframer #(.MAX_BYTES(MAX_BYTES), .MIN_PRE_DIBITS(MIN_PRE)) dut (
      .eth_clk     (eth_clk),
      .rst         (rst),
      .rmii_crs_dv (rmii_crs_dv),
      .rmii_rxd    (rmii_rxd),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_sof      (rx_sof),
      .rx_eof      (rx_eof),
      .rx_err      (rx_err),
      .rx_len      (rx_len)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Edge counter and output monitor (append-only records).
   int               cyc = 0;
   logic [7:0]       got_b[$];
   int               got_e[$];
   bit               got_sof[$];
   int               eof_e[$];
   bit               eof_err[$];
   logic [LEN_W-1:0] eof_len[$];
   int               overlap_n = 0;

   always @(posedge eth_clk) cyc <= cyc + 1;

   always @(negedge eth_clk) begin
      if (rx_valid) begin
         got_b.push_back(rx_data);
         got_e.push_back(cyc);
         got_sof.push_back(rx_sof);
      end
      if (rx_eof) begin
         eof_e.push_back(cyc);
         eof_err.push_back(rx_err);
         eof_len.push_back(rx_len);
      end
      if (rx_valid && rx_eof) overlap_n <= overlap_n + 1;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model state for the frame most recently sent.
   logic [7:0] frame[$];
   logic [7:0] exp_b[$];
   int         exp_e[$];
   int         exp_eof_edge, exp_len;
   bit         exp_eof, exp_err;
   int         b0, f0, o0, last_edge;

   task automatic drive(input logic dv, input logic [1:0] d);
      @(negedge eth_clk);
      rmii_crs_dv = dv;
      rmii_rxd    = d;
      last_edge   = cyc + 1;
   endtask

   // Random payload of n-4 bytes followed by its little-endian FCS.
   task automatic build_frame(input int n);
      logic [31:0] c;
      logic [7:0]  b;
      frame.delete();
      for (int i = 0; i < n - 4; i++) frame.push_back(8'($urandom));
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n - 4; i++) begin
         b = frame[i];
         for (int j = 0; j < 8; j++)
            c = (c[0] ^ b[j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) frame.push_back(c[8*i +: 8]);
   endtask

   task automatic run_frame(input int npre, input int lead00, input int rem,
                            input bit toggle, input bit fcs_bad, input int gap);
      int         d_tot, nb;
      bit         ok, dv;
      logic [7:0] tmp;
      logic [1:0] dib;
      b0 = got_b.size(); f0 = eof_e.size(); o0 = overlap_n;
      exp_b.delete(); exp_e.delete();
      ok = (npre >= MIN_PRE);
      nb = frame.size();
      repeat (lead00) drive(1'b1, 2'b00);
      repeat (npre) drive(1'b1, 2'b01);
      drive(1'b1, 2'b11);
      d_tot = nb * 4 + rem;
      for (int idx = 0; idx < d_tot; idx++) begin
         if (idx < nb * 4) begin
            tmp = frame[idx / 4];
            dib = tmp[2 * (idx % 4) +: 2];
         end else begin
            dib = 2'($urandom);
         end
         dv = !(toggle && idx >= d_tot - 8 && ((idx - (d_tot - 8)) % 2 == 0));
         drive(dv, dib);
         if (ok && idx < nb * 4 && idx % 4 == 3 && idx / 4 < MAX_BYTES) begin
            exp_b.push_back(frame[idx / 4]);
            exp_e.push_back(last_edge + 2);
         end
      end
      drive(1'b0, 2'b00);
      exp_eof_edge = last_edge + 2;
      repeat (gap - 1) drive(1'b0, 2'b00);
      repeat (3) @(negedge eth_clk);
      exp_eof = ok;
      exp_len = (nb > MAX_BYTES) ? MAX_BYTES : nb;
      exp_err = (rem != 0) || (nb > MAX_BYTES) || (CRC_EN && fcs_bad);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge eth_clk);
      n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
      n_cmp++; if (rx_sof !== 1'b0)   begin n_bad++; $display("FAIL reset_sof: got %b expected 0", rx_sof); end
      n_cmp++; if (rx_eof !== 1'b0)   begin n_bad++; $display("FAIL reset_eof: got %b expected 0", rx_eof); end
      n_cmp++; if (rx_err !== 1'b0)   begin n_bad++; $display("FAIL reset_err: got %b expected 0", rx_err); end
      n_cmp++; if (rx_len !== '0)     begin n_bad++; $display("FAIL reset_len: got %0d expected 0", rx_len); end
      n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", rx_data); end
      rst = 1'b0;
      repeat (6) drive(1'b0, 2'b00);
   endtask

   task automatic test_basic;
      build_frame(64);
      run_frame(28, 0, 0, 1'b0, 1'b0, 4);
      n_cmp++; if (got_b.size() - b0 != 64) begin n_bad++; $display("FAIL basic_count: got %0d expected 64", got_b.size() - b0); end
      for (int i = 0; i < exp_b.size() && b0 + i < got_b.size(); i++) begin
         n_cmp++; if (got_b[b0+i] !== exp_b[i]) begin n_bad++; $display("FAIL basic_byte%0d: got %h expected %h", i, got_b[b0+i], exp_b[i]); end
         n_cmp++; if (got_e[b0+i] != exp_e[i]) begin n_bad++; $display("FAIL basic_lat%0d: got edge %0d expected %0d", i, got_e[b0+i], exp_e[i]); end
         n_cmp++; if (got_sof[b0+i] != (i == 0)) begin n_bad++; $display("FAIL basic_sof%0d: got %b expected %b", i, got_sof[b0+i], i == 0); end
      end
      n_cmp++; if (eof_e.size() - f0 != 1) begin n_bad++; $display("FAIL basic_eof_count: got %0d expected 1", eof_e.size() - f0); end
      if (eof_e.size() > f0) begin
         n_cmp++; if (eof_e[f0] != exp_eof_edge) begin n_bad++; $display("FAIL basic_eof_edge: got %0d expected %0d", eof_e[f0], exp_eof_edge); end
         n_cmp++; if (eof_err[f0] !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b expected 0", eof_err[f0]); end
         n_cmp++; if (eof_len[f0] !== LEN_W'(64)) begin n_bad++; $display("FAIL basic_len: got %0d expected 64", eof_len[f0]); end
      end
      n_cmp++; if (overlap_n != o0) begin n_bad++; $display("FAIL basic_overlap: got %0d expected %0d", overlap_n, o0); end
   endtask

   task automatic test_toggle;
      run_frame(28, 0, 0, 1'b1, 1'b0, 4);
      n_cmp++; if (got_b.size() - b0 != 64) begin n_bad++; $display("FAIL toggle_count: got %0d expected 64", got_b.size() - b0); end
      for (int i = 0; i < exp_b.size() && b0 + i < got_b.size(); i++) begin
         n_cmp++; if (got_b[b0+i] !== exp_b[i] || got_e[b0+i] != exp_e[i]) begin
            n_bad++; $display("FAIL toggle_byte%0d: got %h@%0d expected %h@%0d", i, got_b[b0+i], got_e[b0+i], exp_b[i], exp_e[i]);
         end
      end
      n_cmp++; if (eof_e.size() - f0 != 1) begin n_bad++; $display("FAIL toggle_eof_count: got %0d expected 1", eof_e.size() - f0); end
      if (eof_e.size() > f0) begin
         n_cmp++; if (eof_e[f0] != exp_eof_edge) begin n_bad++; $display("FAIL toggle_eof_edge: got %0d expected %0d", eof_e[f0], exp_eof_edge); end
         n_cmp++; if (eof_err[f0] !== 1'b0 || eof_len[f0] !== LEN_W'(64)) begin
            n_bad++; $display("FAIL toggle_eof: got err %b len %0d expected err 0 len 64", eof_err[f0], eof_len[f0]);
         end
      end
   endtask

   task automatic test_remainder;
      build_frame($urandom_range(10, 40));
      run_frame(8, 1, 2, 1'b0, 1'b0, 4);
      n_cmp++; if (got_b.size() - b0 != exp_b.size()) begin n_bad++; $display("FAIL rem_count: got %0d expected %0d", got_b.size() - b0, exp_b.size()); end
      for (int i = 0; i < exp_b.size() && b0 + i < got_b.size(); i++) begin
         n_cmp++; if (got_b[b0+i] !== exp_b[i]) begin n_bad++; $display("FAIL rem_byte%0d: got %h expected %h", i, got_b[b0+i], exp_b[i]); end
      end
      n_cmp++; if (eof_e.size() - f0 != 1) begin n_bad++; $display("FAIL rem_eof_count: got %0d expected 1", eof_e.size() - f0); end
      if (eof_e.size() > f0) begin
         n_cmp++; if (eof_err[f0] !== 1'b1) begin n_bad++; $display("FAIL rem_err: got %b expected 1", eof_err[f0]); end
         n_cmp++; if (eof_len[f0] !== LEN_W'(exp_len)) begin n_bad++; $display("FAIL rem_len: got %0d expected %0d", eof_len[f0], exp_len); end
      end
   endtask

   task automatic test_overflow;
      build_frame(1600);
      run_frame(28, 0, 0, 1'b0, 1'b0, 4);
      n_cmp++; if (got_b.size() - b0 != MAX_BYTES) begin n_bad++; $display("FAIL ovf_count: got %0d expected %0d", got_b.size() - b0, MAX_BYTES); end
      for (int i = 0; i < exp_b.size() && b0 + i < got_b.size(); i++) begin
         n_cmp++; if (got_b[b0+i] !== exp_b[i]) begin n_bad++; $display("FAIL ovf_byte%0d: got %h expected %h", i, got_b[b0+i], exp_b[i]); end
      end
      n_cmp++; if (eof_e.size() - f0 != 1) begin n_bad++; $display("FAIL ovf_eof_count: got %0d expected 1", eof_e.size() - f0); end
      if (eof_e.size() > f0) begin
         n_cmp++; if (eof_err[f0] !== 1'b1) begin n_bad++; $display("FAIL ovf_err: got %b expected 1", eof_err[f0]); end
         n_cmp++; if (eof_len[f0] !== LEN_W'(MAX_BYTES)) begin n_bad++; $display("FAIL ovf_len: got %0d expected %0d", eof_len[f0], MAX_BYTES); end
      end
   endtask

   task automatic test_fcs_flip;
      int k;
      logic [7:0] t;
      build_frame(48);
      k = $urandom_range(0, 47);
      t = frame[k];
      t[$urandom_range(0, 7)] ^= 1'b1;
      frame[k] = t;
      run_frame(12, 0, 0, 1'b0, 1'b1, 4);
      n_cmp++; if (got_b.size() - b0 != 48) begin n_bad++; $display("FAIL fcs_count: got %0d expected 48", got_b.size() - b0); end
      n_cmp++; if (eof_e.size() - f0 != 1) begin n_bad++; $display("FAIL fcs_eof_count: got %0d expected 1", eof_e.size() - f0); end
      if (eof_e.size() > f0) begin
         n_cmp++; if (eof_err[f0] !== exp_err) begin n_bad++; $display("FAIL fcs_err: got %b expected %b", eof_err[f0], exp_err); end
         n_cmp++; if (eof_len[f0] !== LEN_W'(48)) begin n_bad++; $display("FAIL fcs_len: got %0d expected 48", eof_len[f0]); end
      end
   endtask

   task automatic test_short_pre;
      build_frame(20);
      run_frame(2, 0, 0, 1'b0, 1'b0, 4);
      n_cmp++; if (got_b.size() != b0) begin n_bad++; $display("FAIL short_pre_bytes: got %0d expected 0", got_b.size() - b0); end
      n_cmp++; if (eof_e.size() != f0) begin n_bad++; $display("FAIL short_pre_eof: got %0d expected 0", eof_e.size() - f0); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] t;
      build_frame(40);
      repeat (28) drive(1'b1, 2'b01);
      drive(1'b1, 2'b11);
      for (int idx = 0; idx < 32; idx++) begin t = frame[idx / 4]; drive(1'b1, t[2 * (idx % 4) +: 2]); end
      rst = 1'b1;
      for (int idx = 32; idx < 34; idx++) begin t = frame[idx / 4]; drive(1'b1, t[2 * (idx % 4) +: 2]); end
      n_cmp++; if ({rx_valid, rx_sof, rx_eof, rx_err} !== 4'b0 || rx_len !== '0 || rx_data !== 8'h00) begin
         n_bad++; $display("FAIL midrst_clear: got v%b s%b e%b r%b len %0d data %h expected all 0", rx_valid, rx_sof, rx_eof, rx_err, rx_len, rx_data);
      end
      rst = 1'b0;
      b0 = got_b.size(); f0 = eof_e.size();
      for (int idx = 34; idx < 160; idx++) begin t = frame[idx / 4]; drive(1'b1, t[2 * (idx % 4) +: 2]); end
      drive(1'b0, 2'b00);
      drive(1'b0, 2'b00);
      n_cmp++; if (got_b.size() != b0) begin n_bad++; $display("FAIL midrst_bytes: got %0d expected 0", got_b.size() - b0); end
      n_cmp++; if (eof_e.size() != f0) begin n_bad++; $display("FAIL midrst_eof: got %0d expected 0", eof_e.size() - f0); end
      build_frame(32);
      run_frame(16, 0, 0, 1'b0, 1'b0, 4);
      n_cmp++; if (got_b.size() - b0 != 32) begin n_bad++; $display("FAIL midrst_next_count: got %0d expected 32", got_b.size() - b0); end
      for (int i = 0; i < exp_b.size() && b0 + i < got_b.size(); i++) begin
         n_cmp++; if (got_b[b0+i] !== exp_b[i]) begin n_bad++; $display("FAIL midrst_next_byte%0d: got %h expected %h", i, got_b[b0+i], exp_b[i]); end
      end
      n_cmp++; if (eof_e.size() - f0 != 1) begin n_bad++; $display("FAIL midrst_next_eof: got %0d expected 1", eof_e.size() - f0); end
      if (eof_e.size() > f0) begin
         n_cmp++; if (eof_err[f0] !== 1'b0 || eof_len[f0] !== LEN_W'(32)) begin
            n_bad++; $display("FAIL midrst_next_result: got err %b len %0d expected err 0 len 32", eof_err[f0], eof_len[f0]);
         end
      end
   endtask

   task automatic test_back_to_back;
      int  npre, len, rem;
      bit  tog, flip;
      logic [7:0] t;
      for (int f = 0; f < 6; f++) begin
         npre = $urandom_range(2, 10);
         len  = $urandom_range(5, 30);
         rem  = $urandom_range(0, 3);
         tog  = 1'($urandom_range(0, 1));
         flip = ($urandom_range(0, 3) == 0);
         build_frame(len);
         if (flip) begin t = frame[0]; t[0] = ~t[0]; frame[0] = t; end
         run_frame(npre, $urandom_range(0, 2), rem, tog, flip, 2);
         n_cmp++; if (got_b.size() - b0 != exp_b.size()) begin n_bad++; $display("FAIL b2b%0d_count: got %0d expected %0d", f, got_b.size() - b0, exp_b.size()); end
         for (int i = 0; i < exp_b.size() && b0 + i < got_b.size(); i++) begin
            n_cmp++; if (got_b[b0+i] !== exp_b[i] || got_e[b0+i] != exp_e[i] || got_sof[b0+i] != (i == 0)) begin
               n_bad++; $display("FAIL b2b%0d_byte%0d: got %h@%0d sof %b expected %h@%0d sof %b", f, i, got_b[b0+i], got_e[b0+i], got_sof[b0+i], exp_b[i], exp_e[i], i == 0);
            end
         end
         n_cmp++; if (eof_e.size() - f0 != int'(exp_eof)) begin n_bad++; $display("FAIL b2b%0d_eof_count: got %0d expected %0d", f, eof_e.size() - f0, exp_eof); end
         if (exp_eof && eof_e.size() > f0) begin
            n_cmp++; if (eof_e[f0] != exp_eof_edge || eof_err[f0] !== exp_err || eof_len[f0] !== LEN_W'(exp_len)) begin
               n_bad++; $display("FAIL b2b%0d_eof: got @%0d err %b len %0d expected @%0d err %b len %0d", f, eof_e[f0], eof_err[f0], eof_len[f0], exp_eof_edge, exp_err, exp_len);
            end
         end
         n_cmp++; if (overlap_n != o0) begin n_bad++; $display("FAIL b2b%0d_overlap: got %0d expected %0d", f, overlap_n, o0); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_toggle();
      test_remainder();
      test_overflow();
      test_fcs_flip();
      test_short_pre();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rmii_rx_deframer.md
# rmii_rx_deframer

Receive-side RMII deframer for the 100 Mbit/s PHY link. It runs in the 50 MHz eth_clk domain and is held in reset by the Ethernet reset generator's eth_rst. It samples CRS_DV/RXD[1:0] and strips the preamble and SFD. Payload bytes (including FCS) are delivered as single-cycle strobes to the MAC receive logic, with start/end-of-frame markers, frame length and an error flag.

## Interface
- MAX_BYTES, 1522: maximum bytes accepted after the SFD, FCS included.
- MIN_PRE_DIBITS, 4: minimum count of 2'b01 preamble dibits required before the SFD dibit.
- eth_clk  in  1  50 MHz RMII reference clock.
- rst  in  1  reset: synchronous, active-high, sampled on eth_clk.
- rmii_crs_dv  in  1  PHY carrier-sense/data-valid.
- rmii_rxd  in  2  PHY receive dibit, LSB first.
- rx_data  out  8  received byte; valid only while rx_valid is high.
- rx_valid  out  1  one-cycle strobe per byte.
- rx_sof  out  1  high with rx_valid on the first byte after the SFD.
- rx_eof  out  1  one-cycle end-of-frame strobe; never coincident with rx_valid.
- rx_err  out  1  qualified by rx_eof; frame is bad.
- rx_len  out  $clog2(MAX_BYTES+1)  bytes delivered in the frame; qualified by rx_eof.

## Operation
- Input stage: rmii_crs_dv and rmii_rxd are registered once (IOB), then delayed one more stage. A dibit sampled with crs_dv low is committed only if crs_dv is high on the following sample. This absorbs PHY CRS_DV toggling at end of carrier.
- End of frame: crs_dv is low on two consecutive samples.
- States and transitions:
  - DISARM: entered from reset. Go to IDLE after two consecutive low crs_dv samples.
  - IDLE: go to PREAMBLE on crs_dv high.
  - PREAMBLE: 2'b00 dibits are ignored before the first 2'b01. 2'b01 increments the preamble count. 2'b11 with count ≥ MIN_PRE_DIBITS goes to DATA. Any other dibit, or 2'b11 with count below the minimum, goes to DROP. End of frame returns to IDLE. In both failure cases there is no output.
  - DATA: dibits shift in LSB first. Every 4th dibit emits a byte and increments the byte count. Reaching MAX_BYTES sets the error and stops byte emission, but the state stays in DATA. End of frame emits rx_eof and returns to IDLE.
  - DROP: wait for end of frame, then go to IDLE. Nothing is emitted.
- Error at rx_eof is set by any of:
  - a dibit remainder (count not a multiple of 4); the partial byte is discarded;
  - the MAX_BYTES overflow;
  - a CRC failure (when compiled in).
- rx_len saturates at MAX_BYTES.
- Reset mid-frame: outputs clear immediately and the state goes to DISARM, so the remainder of an in-flight frame is never decoded.

## Timing
- Reset values: rx_data=0; rx_valid, rx_sof, rx_eof, rx_err = 0; rx_len=0.
- Byte latency: rx_valid is registered at edge k+2, where k is the eth_clk edge that samples the byte's 4th dibit. Latency is constant regardless of CRS_DV toggling.
- rx_eof is registered at edge m+2, where m is the first low sample of the terminating pair. It is at least one cycle after the last rx_valid.
- Byte strobes are at least 4 cycles apart. There is no backpressure, and the consumer must accept every strobe.

## Configuration
- RMII_RX_CRC_CHECK_EN defined:
  - A reflected CRC-32 (poly 0xEDB88320, init 0xFFFFFFFF) runs over every delivered byte, FCS included.
  - At rx_eof, a register value other than 0xDEBB20E3 sets rx_err.
  - The CRC resets on SFD.
- Undefined: no CRC logic; rx_err reflects only the remainder and overflow errors.

## Structure
- eth_pkg holds:
  - the state enum;
  - the PREAMBLE_DIBIT (2'b01) and SFD_DIBIT (2'b11) constants;
  - the CRC32_POLY, CRC32_INIT and CRC32_RESIDUE constants.
- Sub-module crc32_d8: a combinational byte-wide CRC next-state. It is instantiated only under RMII_RX_CRC_CHECK_EN.

## Test plan
- 28×01 + 11, then 64 bytes with a valid FCS → 64 rx_valid, rx_sof on byte 0, rx_eof with rx_err=0 and rx_len=64; byte values match.
- Same frame with CRS_DV toggling (low/high per dibit) over the last 8 dibits → identical bytes; rx_eof only after two consecutive lows.
- Frame ending 2 dibits past a byte boundary → the partial byte is not emitted; rx_eof with rx_err=1.
- 1600-byte frame, MAX_BYTES=1522 → exactly 1522 rx_valid; rx_eof with rx_err=1 and rx_len=1522.
- One FCS bit flipped → rx_err=1 with RMII_RX_CRC_CHECK_EN defined, 0 without it. Preamble of only 2×01 before the SFD → no output at all.
- rst pulsed mid-frame and released while crs_dv is high → no output for that frame. The next frame, after crs_dv low for 2 cycles, is received correctly.
